// File: rtl/ledmatrix_pkg.sv
// -----------------------------------------------------------------------------
// ledmatrix_pkg
//
// Shared definitions for the LED-matrix serial receiver.
//   - Register address map of the MAX7219-style register file.
//   - Frame-state encoding of the receiver.
//   - Bit-counter width and its saturation value.
// No ports: imported with "import ledmatrix_pkg::*;".
// -----------------------------------------------------------------------------
package ledmatrix_pkg;

    // Register address map (address field of the received word)
    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    // The bit counter saturates instead of wrapping, so an overlong frame
    // can never alias back to a legal length.
    localparam int               CNT_W   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE,
        RECV
    } frame_state_e;

endpackage

// File: rtl/ledmatrix_serial_rx_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
//
// Brings one asynchronous bus line into the slow_clk domain through a chain
// of STAGES flip-flops, then one more delay flop used for edge detection.
//
// Ports:
//   slow_clk : sampling clock
//   rst      : asynchronous, active-high reset
//   d        : raw asynchronous input
//   level    : synchronized level (last synchronizer stage)
//   rise     : one-cycle pulse, level went 0 -> 1
//   fall     : one-cycle pulse, level went 1 -> 0
//
// RST_VAL sets the value the chain and delay flop reset to. Resetting a line
// to 1 means a line already high when reset releases produces no rise; only
// a genuine low-then-high transition does.
// -----------------------------------------------------------------------------
module sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic slow_clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              dly_q;

    // NOTE: clocked state is always assigned with <=, so every flop samples
    // the pre-edge value of its neighbour and the chain shifts one step per
    // clock regardless of statement order.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(d);
            dly_q  <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~dly_q;
    assign fall  = ~level & dly_q;

endmodule

// File: rtl/ledmatrix_serial_rx.sv
// -----------------------------------------------------------------------------
// ledmatrix_serial_rx
//
// Receiver end of the three-wire LED-matrix serial bus. Oversamples the bus
// on slow_clk, assembles BITS-bit address/data words and decodes them into a
// MAX7219-style digit and control register file. Used as a loopback checker
// and display emulator next to the transmitter.
//
// Ports:
//   slow_clk       : sampling clock, at least 4x the serial bit clock
//   rst            : asynchronous, active-high reset
//   in_ser_clk     : serial clock, data sampled on its rising edge
//   in_ser_dat     : serial data
//   in_ser_sel     : active-high frame select, high for the whole frame
//   out_digits     : digit n (1-based) at [DATA_BITS*(n-1) +: DATA_BITS]
//   out_decode     : decode-mode register (address 0x9)
//   out_intensity  : intensity register (address 0xA, data[3:0])
//   out_scanlimit  : scan-limit register (address 0xB, data[2:0])
//   out_shutdown   : 1 = shut down (address 0xC writes ~data[0])
//   out_test       : display-test register (address 0xF, data[0])
//   out_word       : last valid received word
//   out_word_valid : one-cycle pulse per frame of exactly BITS bits
//   out_frame_err  : one-cycle pulse per frame of any other length
//
// Latency from the select falling edge at the pin to registered outputs and
// pulses is SYNC_STAGES+1 slow_clk edges.
// -----------------------------------------------------------------------------
module ledmatrix_serial_rx #(
    parameter int BITS          = 16,
    parameter int ADDR_BITS     = 4,
    parameter int DATA_BITS     = 8,
    parameter int NUM_SEGS      = 8,
    parameter int SYNC_STAGES   = 2,
    parameter bit HIGHBIT_FIRST = 1'b1
) (
    input  logic                          slow_clk,
    input  logic                          rst,
    input  logic                          in_ser_clk,
    input  logic                          in_ser_dat,
    input  logic                          in_ser_sel,
    output logic [NUM_SEGS*DATA_BITS-1:0] out_digits,
    output logic [7:0]                    out_decode,
    output logic [3:0]                    out_intensity,
    output logic [2:0]                    out_scanlimit,
    output logic                          out_shutdown,
    output logic                          out_test,
    output logic [BITS-1:0]               out_word,
    output logic                          out_word_valid,
    output logic                          out_frame_err
);

    import ledmatrix_pkg::*;

    // -------------------------------------------------------------------------
    // Input synchronization. All three lines go through identical chains so
    // the data level is aligned with the detected clock edge.
    // -------------------------------------------------------------------------
    logic sel_level, sel_rise, sel_fall;
    logic clk_rise;
    logic dat_level;
    logic clk_level_unused, clk_fall_unused;
    logic dat_rise_unused, dat_fall_unused;

    // Select resets high so a frame already in progress when reset releases
    // is ignored until the next genuine rising edge of select.
    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_sel (
        .slow_clk (slow_clk),
        .rst      (rst),
        .d        (in_ser_sel),
        .level    (sel_level),
        .rise     (sel_rise),
        .fall     (sel_fall)
    );

    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_clk (
        .slow_clk (slow_clk),
        .rst      (rst),
        .d        (in_ser_clk),
        .level    (clk_level_unused),
        .rise     (clk_rise),
        .fall     (clk_fall_unused)
    );

    sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_dat (
        .slow_clk (slow_clk),
        .rst      (rst),
        .d        (in_ser_dat),
        .level    (dat_level),
        .rise     (dat_rise_unused),
        .fall     (dat_fall_unused)
    );

    // -------------------------------------------------------------------------
    // Receive state, shifter, bit counter and register file
    // -------------------------------------------------------------------------
    frame_state_e            state_q;
    logic [BITS-1:0]         shift_q;
    logic [CNT_W-1:0]        bit_cnt_q;

    logic [ADDR_BITS-1:0]    rx_addr;
    logic [DATA_BITS-1:0]    rx_data;
    logic [BITS-1:0]         shift_next;

    // Address and data fields of the word currently held in the shifter;
    // bits above the address field are carried in out_word only.
    assign rx_addr = shift_q[DATA_BITS +: ADDR_BITS];
    assign rx_data = shift_q[DATA_BITS-1:0];

    // MSB-first shifts left so the first bit ends up in the word MSB;
    // LSB-first shifts right so the first bit ends up in bit 0. Either way
    // only the most recent BITS bits are kept.
    assign shift_next = HIGHBIT_FIRST ? {shift_q[BITS-2:0], dat_level}
                                      : {dat_level, shift_q[BITS-1:1]};

    // NOTE: the digit registers form a small flop array rather than a RAM,
    // and the display must come up blank, so every entry is reset; a real
    // memory macro would not be reset this way.
    always_ff @(posedge slow_clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            out_digits     <= '0;
            out_decode     <= '0;
            out_intensity  <= '0;
            out_scanlimit  <= '0;
            out_shutdown   <= 1'b1;
            out_test       <= 1'b0;
            out_word       <= '0;
            out_word_valid <= 1'b0;
            out_frame_err  <= 1'b0;
        end else begin
            // Status pulses are high for exactly the evaluation cycle.
            out_word_valid <= 1'b0;
            out_frame_err  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (sel_rise) begin
                        state_q   <= RECV;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                    end
                end

                RECV: begin
                    if (sel_fall) begin
                        // End of frame; a clock edge in this same cycle is
                        // deliberately dropped.
                        state_q <= IDLE;
                        if (bit_cnt_q == CNT_W'(BITS)) begin
                            out_word       <= shift_q;
                            out_word_valid <= 1'b1;

                            for (int n = 0; n < NUM_SEGS; n++) begin
                                if (rx_addr == ADDR_BITS'(int'(ADDR_DIGIT0) + n)) begin
                                    out_digits[n*DATA_BITS +: DATA_BITS] <= rx_data;
                                end
                            end

                            case (rx_addr)
                                ADDR_BITS'(ADDR_DECODE):    out_decode    <= 8'(rx_data);
                                ADDR_BITS'(ADDR_INTENSITY): out_intensity <= rx_data[3:0];
                                ADDR_BITS'(ADDR_SCANLIMIT): out_scanlimit <= rx_data[2:0];
                                ADDR_BITS'(ADDR_SHUTDOWN):  out_shutdown  <= ~rx_data[0];
                                ADDR_BITS'(ADDR_TEST):      out_test      <= rx_data[0];
                                // No-op, digits and unmapped addresses only
                                // pulse out_word_valid here.
                                default: ;
                            endcase
                        end else begin
                            out_frame_err <= 1'b1;
                        end
                    end else if (clk_rise && sel_level) begin
                        shift_q <= shift_next;
                        if (bit_cnt_q != CNT_MAX) begin
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
